// File: rtl/i2c_bit_engine.sv
// ---------------------------------------------------------------------------
// i2c_bit_engine
//   I2C master bit-level engine. Each accepted go runs one bus primitive
//   (START, STOP, DATA_0/1, ACK/NACK, READ) over four quarters of
//   QUARTER_DIV clock cycles each, driving open-drain enables for SCL/SDA
//   and sampling SDA back at the end of the high phase.
//
// Parameters
//   QUARTER_DIV  clock cycles per quarter bit period (>= 1)
//
// Build option
//   I2C_CLOCK_STRETCH_EN  when defined, the divider is frozen during Q1 while
//                         scl_in reads low (slave clock stretching). When
//                         undefined, scl_in is ignored and timing is fixed.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   go       in   command request, sampled only while idle
//   command  in   000 NOP, 001 READ, 010 START, 011 STOP,
//                 100 DATA_0, 101 DATA_1, 110 ACK, 111 NACK
//   busy     out  high while a primitive is executing
//   finish   out  one-cycle pulse on the last cycle of a primitive
//   rx_bit   out  SDA value sampled during the latest data-type primitive
//   scl_oe   out  1 = pull SCL low, 0 = release
//   sda_oe   out  1 = pull SDA low, 0 = release
//   scl_in   in   SCL readback (already synchronised)
//   sda_in   in   SDA readback (already synchronised)
// ---------------------------------------------------------------------------
module i2c_bit_engine #(
  parameter int QUARTER_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [2:0] command,
  output logic       busy,
  output logic       finish,
  output logic       rx_bit,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_STOP  = 3'b011;
  localparam logic [2:0] CMD_DATA0 = 3'b100;
  localparam logic [2:0] CMD_ACK   = 3'b110;

  localparam int DIV_W = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QUARTER_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       quarter_reg, quarter_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]       cmd_reg, cmd_next;
  logic             scl_oe_reg, scl_oe_next;
  logic             sda_oe_reg, sda_oe_next;
  logic             rx_bit_reg, rx_bit_next;
  logic             nop_done_reg, nop_done_next;
  logic             div_freeze;
  logic             is_data;

  // Line enables {scl_oe, sda_oe} for a given command and quarter.
  function automatic logic [1:0] line_levels(input logic [2:0] cmd, input logic [1:0] q);
    logic [1:0] lv;
    lv = 2'b00;
    case (cmd)
      CMD_START: case (q)
        2'd0: lv = 2'b10;
        2'd1: lv = 2'b00;
        2'd2: lv = 2'b01;
        default: lv = 2'b11;
      endcase
      CMD_STOP: case (q)
        2'd0: lv = 2'b11;
        2'd1: lv = 2'b01;
        default: lv = 2'b00;
      endcase
      default: begin
        // Data-type bit: SCL low at the edges, SDA constant for the whole bit.
        lv[1] = (q == 2'd0) || (q == 2'd3);
        lv[0] = (cmd == CMD_DATA0) || (cmd == CMD_ACK);
      end
    endcase
    return lv;
  endfunction

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low during the high phase stalls the divider, so Q1
  // is measured from the moment SCL actually rises.
  assign div_freeze = (state_reg == RUN) && (quarter_reg == 2'd1) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign div_freeze    = 1'b0;
`endif

  assign is_data = (cmd_reg != CMD_START) && (cmd_reg != CMD_STOP);

  always_comb begin
    state_next    = state_reg;
    quarter_next  = quarter_reg;
    div_next      = div_reg;
    cmd_next      = cmd_reg;
    scl_oe_next   = scl_oe_reg;
    sda_oe_next   = sda_oe_reg;
    rx_bit_next   = rx_bit_reg;
    nop_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          if (command == CMD_NOP) begin
            nop_done_next = 1'b1;
          end else begin
            state_next   = RUN;
            cmd_next     = command;
            quarter_next = 2'd0;
            div_next     = '0;
            {scl_oe_next, sda_oe_next} = line_levels(command, 2'd0);
          end
        end
      end
      RUN: begin
        if (!div_freeze) begin
          if (div_reg == DIV_LAST) begin
            div_next = '0;
            if (quarter_reg == 2'd3) begin
              // Lines keep their Q3 levels while idle (released after STOP).
              state_next = IDLE;
            end else begin
              quarter_next = quarter_reg + 2'd1;
              {scl_oe_next, sda_oe_next} = line_levels(cmd_reg, quarter_reg + 2'd1);
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
        if ((quarter_reg == 2'd2) && (div_reg == DIV_LAST) && is_data)
          rx_bit_next = sda_in;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      quarter_reg  <= 2'd0;
      div_reg      <= '0;
      cmd_reg      <= CMD_NOP;
      scl_oe_reg   <= 1'b0;
      sda_oe_reg   <= 1'b0;
      rx_bit_reg   <= 1'b0;
      nop_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      quarter_reg  <= quarter_next;
      div_reg      <= div_next;
      cmd_reg      <= cmd_next;
      scl_oe_reg   <= scl_oe_next;
      sda_oe_reg   <= sda_oe_next;
      rx_bit_reg   <= rx_bit_next;
      nop_done_reg <= nop_done_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign finish = ((state_reg == RUN) && (quarter_reg == 2'd3) && (div_reg == DIV_LAST))
                  || nop_done_reg;
  assign rx_bit = rx_bit_reg;
  assign scl_oe = scl_oe_reg;
  assign sda_oe = sda_oe_reg;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// ---------------------------------------------------------------------------
// tb_i2c_bit_engine
//   Self-checking bench for i2c_bit_engine with QUARTER_DIV=2. A behavioural
//   model derives the expected per-cycle line levels from the quarter tables,
//   the expected rx_bit from the simulated slave and the wired-AND SDA line,
//   and the idle levels left behind by each primitive.
// ---------------------------------------------------------------------------
module tb_i2c_bit_engine;

  localparam int QD = 2;
  localparam int NCYC = 4 * QD;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [2:0] command = 3'b000;
  logic       busy, finish, rx_bit, scl_oe, sda_oe;
  logic       scl_in, sda_in;
  logic       slave_bit = 1'b1;
  logic       stretch = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model state: levels left on the bus while idle, and last sampled bit.
  logic idle_scl_m = 1'b0;
  logic idle_sda_m = 1'b0;
  logic rx_m = 1'b0;

  // Open-drain bus: line is low if anybody pulls it.
  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & slave_bit;

  always #5 clock = ~clock;

  i2c_bit_engine #(.QUARTER_DIV(QD)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .command(command),
    .busy(busy), .finish(finish), .rx_bit(rx_bit),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Quarter table from the bus protocol: 'L' = driven low, 'H' = released.
  function automatic logic exp_oe(input bit is_scl, input logic [2:0] cmd, input int q);
    string pat;
    case (cmd)
      3'b010:         pat = is_scl ? "LHHL" : "HHLL";
      3'b011:         pat = is_scl ? "LHHH" : "LLHH";
      3'b100, 3'b110: pat = is_scl ? "LHHL" : "LLLL";
      default:        pat = is_scl ? "LHHL" : "HHHH";
    endcase
    return pat[q] == "L";
  endfunction

  // Run one primitive and check it cycle by cycle; noise drives go/command
  // randomly while the engine is busy.
  task automatic run_cmd(input logic [2:0] cmd, input logic slave, input bit noise);
    int q;
    @(posedge clock); #1;
    go = 1'b1; command = cmd; slave_bit = slave;
    @(posedge clock); #1;
    go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    command = 3'($urandom);
    for (int k = 1; k <= NCYC; k++) begin
      q = (k - 1) / QD;
      @(negedge clock);
      check_eq("busy_run", busy, 1);
      check_eq("finish_run", finish, (k == NCYC));
      check_eq("scl_run", scl_oe, exp_oe(1'b1, cmd, q));
      check_eq("sda_run", sda_oe, exp_oe(1'b0, cmd, q));
      if (q == 2 && (k % QD) == 0 && cmd != 3'b010 && cmd != 3'b011)
        rx_m = slave & ~exp_oe(1'b0, cmd, 2);
      @(posedge clock); #1;
      go = (noise && k + 1 <= NCYC) ? 1'($urandom_range(0, 1)) : 1'b0;
      command = 3'($urandom);
    end
    idle_scl_m = exp_oe(1'b1, cmd, 3);
    idle_sda_m = exp_oe(1'b0, cmd, 3);
    @(negedge clock);
    check_eq("busy_after", busy, 0);
    check_eq("finish_after", finish, 0);
    check_eq("scl_idle", scl_oe, idle_scl_m);
    check_eq("sda_idle", sda_oe, idle_sda_m);
    check_eq("rx_bit", rx_bit, rx_m);
    $display("txn cmd=%0d slave=%0d noise=%0d rx_bit=%0d scl_oe=%0d sda_oe=%0d",
             cmd, slave, noise, rx_bit, scl_oe, sda_oe);
  endtask

  initial begin : main
    int fin_cnt;
    int fin_first;
    int fin_second;
    logic [2:0] rc;

    // Reset state
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_finish", finish, 0);
    check_eq("rst_rx", rx_bit, 0);
    check_eq("rst_scl", scl_oe, 0);
    check_eq("rst_sda", sda_oe, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // START from idle, then READ with both slave values
    run_cmd(3'b010, 1'b1, 1'b0);
    run_cmd(3'b001, 1'b0, 1'b0);
    run_cmd(3'b001, 1'b1, 1'b0);

    // NOP: one finish pulse, not busy, lines untouched
    @(posedge clock); #1;
    go = 1'b1; command = 3'b000;
    @(posedge clock); #1;
    go = 1'b0;
    @(negedge clock);
    check_eq("nop_finish", finish, 1);
    check_eq("nop_busy", busy, 0);
    check_eq("nop_scl", scl_oe, idle_scl_m);
    check_eq("nop_sda", sda_oe, idle_sda_m);
    @(negedge clock);
    check_eq("nop_finish_end", finish, 0);
    $display("txn cmd=0 nop finish seen");

    // Randomised primitives with go/command noise while busy
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(1, 7));
      run_cmd(rc, 1'($urandom_range(0, 1)), 1'b1);
    end

    // DATA_1 then STOP with go held high
    @(posedge clock); #1;
    go = 1'b1; command = 3'b101; slave_bit = 1'b1;
    fin_cnt = 0; fin_first = -1; fin_second = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clock); #1;
      if (k == 1) command = 3'b011;
      if (k == 12) go = 1'b0;
      @(negedge clock);
      if (k == 9) check_eq("b2b_idle_gap", busy, 0);
      if (finish) begin
        fin_cnt++;
        if (fin_first < 0) fin_first = k;
        else if (fin_second < 0) fin_second = k;
      end
    end
    check_eq("b2b_fin_count", fin_cnt, 2);
    check_eq("b2b_fin_first", fin_first, 8);
    check_eq("b2b_fin_gap", fin_second - fin_first, 9);
    check_eq("b2b_scl", scl_oe, 0);
    check_eq("b2b_sda", sda_oe, 0);
    check_eq("b2b_rx", rx_bit, 1);
    idle_scl_m = 1'b0; idle_sda_m = 1'b0; rx_m = 1'b1;
    $display("txn b2b DATA_1+STOP finishes=%0d first=%0d second=%0d", fin_cnt, fin_first, fin_second);

    // Reset in the middle of DATA_0
    @(posedge clock); #1;
    go = 1'b1; command = 3'b100;
    @(posedge clock); #1;
    go = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_eq("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_scl", scl_oe, 0);
    check_eq("mid_rst_sda", sda_oe, 0);
    check_eq("mid_rst_finish", finish, 0);
    check_eq("mid_rst_rx", rx_bit, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle_scl_m = 1'b0; idle_sda_m = 1'b0; rx_m = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (finish) fin_cnt++;
    end
    check_eq("rst_no_finish", fin_cnt, 0);
    $display("txn reset mid DATA_0 finishes=%0d", fin_cnt);
    run_cmd(3'b100, 1'b1, 1'b0);

    // Clock stretching: hold SCL low for 5 cycles of Q1
    @(posedge clock); #1;
    go = 1'b1; command = 3'b101; slave_bit = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    fin_cnt = 0; fin_first = -1;
    for (int k = 1; k <= 30; k++) begin
      stretch = (k >= 3 && k <= 7);
      @(negedge clock);
      if (finish) begin
        fin_cnt++;
        if (fin_first < 0) fin_first = k;
      end
      @(posedge clock); #1;
    end
    stretch = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
    check_eq("stretch_len", fin_first, 13);
`else
    check_eq("stretch_len", fin_first, 8);
`endif
    check_eq("stretch_fin_count", fin_cnt, 1);
    check_eq("stretch_rx", rx_bit, 1);
    check_eq("stretch_scl", scl_oe, 1);
    check_eq("stretch_sda", sda_oe, 0);
    $display("txn stretch DATA_1 cycles=%0d finishes=%0d", fin_first, fin_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
